// File: rtl/if_fetch_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//   mem_req_o   : fetch -> memory, read request (held until acknowledged)
//   mem_addr_o  : fetch -> memory, word-aligned read address
//   mem_ack_i   : memory -> fetch, read complete this cycle
//   mem_rdata_i : memory -> fetch, instruction word, valid with mem_ack_i
interface if_fetch_if;
  localparam int unsigned XLEN = 32;

  logic            mem_req_o;
  logic [XLEN-1:0] mem_addr_o;
  logic            mem_ack_i;
  logic [XLEN-1:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_ack_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_ack_i,
    output mem_rdata_i
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: one-outstanding req/ack reads from instruction
// memory, an output register plus one-entry skid buffer towards decode, and
// branch redirects that squash wrong-path data and in-flight responses.
//   clk, rst                : clock, synchronous active-high reset
//   stall_i                 : decode not accepting; hold the output register
//   branch_flag_i           : redirect request from decode
//   branch_target_address_i : redirect target (low two bits ignored)
//   mem                     : instruction-memory bus (master side)
//   pc_o, inst_o            : presented instruction and its PC (registered)
//   inst_valid_o            : pc_o/inst_o valid (registered)
//   fetch_stall_o           : combinational, !inst_valid_o
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  if_fetch_if.master  mem,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        fetch_stall_o
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  // START: first cycle after reset, no request yet.
  // FETCH: request outstanding. DROP: request outstanding, response discarded.
  // FULL: output and skid both valid, no request.
  typedef enum logic [1:0] {S_START, S_FETCH, S_DROP, S_FULL} state_t;

  state_t          state, state_n;
  logic            req_q, req_n;
  logic [XLEN-1:0] addr_q, addr_n;
  logic [XLEN-1:0] fetch_pc, fetch_pc_n;
  logic [XLEN-1:0] pc_n, inst_n;
  logic            valid_n;
  logic            skid_valid, skid_valid_n;
  logic [XLEN-1:0] skid_pc, skid_pc_n;
  logic [XLEN-1:0] skid_inst, skid_inst_n;

  logic            consume, redirect, done;
  logic [XLEN-1:0] target;

  assign consume  = inst_valid_o & ~stall_i;
  assign redirect = branch_flag_i & ~stall_i;
  assign done     = req_q & mem.mem_ack_i;
  assign target   = branch_target_address_i & ~XLEN'(3);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_START;
      req_q        <= 1'b0;
      addr_q       <= '0;
      fetch_pc     <= RESET_PC;
      pc_o         <= '0;
      inst_o       <= '0;
      inst_valid_o <= 1'b0;
      skid_valid   <= 1'b0;
      skid_pc      <= '0;
      skid_inst    <= '0;
    end else begin
      state        <= state_n;
      req_q        <= req_n;
      addr_q       <= addr_n;
      fetch_pc     <= fetch_pc_n;
      pc_o         <= pc_n;
      inst_o       <= inst_n;
      inst_valid_o <= valid_n;
      skid_valid   <= skid_valid_n;
      skid_pc      <= skid_pc_n;
      skid_inst    <= skid_inst_n;
    end
  end

  // Next-state, buffer fill and request issue
  always_comb begin
    state_n      = state;
    req_n        = req_q;
    addr_n       = addr_q;
    fetch_pc_n   = fetch_pc;
    pc_n         = pc_o;
    inst_n       = inst_o;
    valid_n      = inst_valid_o;
    skid_valid_n = skid_valid;
    skid_pc_n    = skid_pc;
    skid_inst_n  = skid_inst;

    // Consumed output is refilled from the skid buffer first.
    if (consume) begin
      if (skid_valid) begin
        valid_n      = 1'b1;
        pc_n         = skid_pc;
        inst_n       = skid_inst;
        skid_valid_n = 1'b0;
      end else begin
        valid_n = 1'b0;
      end
    end

    if (redirect) begin
      valid_n      = 1'b0;
      skid_valid_n = 1'b0;
      if ((state == S_FETCH || state == S_DROP) && !done) begin
        // Response still in flight: remember the target, discard the response.
        state_n    = S_DROP;
        fetch_pc_n = target;
      end else begin
        state_n    = S_FETCH;
        req_n      = 1'b1;
        addr_n     = target;
        fetch_pc_n = target + STEP;
      end
    end else begin
      case (state)
        S_START: begin
          state_n    = S_FETCH;
          req_n      = 1'b1;
          addr_n     = fetch_pc;
          fetch_pc_n = fetch_pc + STEP;
        end
        S_FETCH: begin
          if (done) begin
            if (!valid_n) begin
              valid_n = 1'b1;
              pc_n    = addr_q;
              inst_n  = mem.mem_rdata_i;
            end else begin
              skid_valid_n = 1'b1;
              skid_pc_n    = addr_q;
              skid_inst_n  = mem.mem_rdata_i;
            end
            // Keep streaming only while the skid buffer has room.
            if (!skid_valid_n) begin
              req_n      = 1'b1;
              addr_n     = fetch_pc;
              fetch_pc_n = fetch_pc + STEP;
            end else begin
              req_n   = 1'b0;
              state_n = S_FULL;
            end
          end
        end
        S_DROP: begin
          if (done) begin
            state_n    = S_FETCH;
            req_n      = 1'b1;
            addr_n     = fetch_pc;
            fetch_pc_n = fetch_pc + STEP;
          end
        end
        S_FULL: begin
          if (!skid_valid_n) begin
            state_n    = S_FETCH;
            req_n      = 1'b1;
            addr_n     = fetch_pc;
            fetch_pc_n = fetch_pc + STEP;
          end
        end
        default: state_n = S_START;
      endcase
    end
  end

  assign mem.mem_req_o  = req_q;
  assign mem.mem_addr_o = addr_q;
  assign fetch_stall_o  = ~inst_valid_o;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a latency-programmable memory model.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch;
  logic [31:0] target;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        valid;
  logic        fstall;

  int          lat;
  int          cnt;
  logic        ack_force;
  int          tests_run;
  int          tests_failed;

  if_fetch_if bus ();

  if_fetch #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall_i                 (stall),
    .branch_flag_i           (branch),
    .branch_target_address_i (target),
    .mem                     (bus.master),
    .pc_o                    (pc),
    .inst_o                  (inst),
    .inst_valid_o            (valid),
    .fetch_stall_o           (fstall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: ack in the lat-th cycle a request is visible (0/1 = zero-wait).
  always @(posedge clk) begin
    if (!bus.mem_req_o || bus.mem_ack_i) cnt <= 0;
    else                                 cnt <= cnt + 1;
  end

  always_comb begin
    bus.mem_ack_i = ack_force | (bus.mem_req_o & ((lat <= 1) || (cnt >= lat - 1)));
  end

  assign bus.mem_rdata_i = bus.mem_addr_o + 32'h1000_0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cnt          = 0;
    rst          = 1'b1;
    stall        = 1'b0;
    branch       = 1'b0;
    target       = '0;
    lat          = 0;
    ack_force    = 1'b0;

    // 1: reset, then zero-wait streaming
    step();
    step();
    check("rst_req",    32'(bus.mem_req_o), 32'd0);
    check("rst_addr",   bus.mem_addr_o,     32'h0);
    check("rst_pc",     pc,                 32'h0);
    check("rst_inst",   inst,               32'h0);
    check("rst_valid",  32'(valid),         32'd0);
    check("rst_fstall", 32'(fstall),        32'd1);
    rst = 1'b0;
    step();
    check("t1_req0",   32'(bus.mem_req_o), 32'd1);
    check("t1_addr0",  bus.mem_addr_o,     32'h0);
    check("t1_valid0", 32'(valid),         32'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("t1_addr",  bus.mem_addr_o, 32'(4 * i));
      check("t1_pc",    pc,             32'(4 * (i - 1)));
      check("t1_inst",  inst,           32'(4 * (i - 1)) + 32'h1000_0000);
      check("t1_valid", 32'(valid),     32'd1);
    end

    // 3: stall while pc_o = 8; skid captures 0xC and the request drops
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_hold_pc",  pc,                 32'h8);
      check("t3_hold_val", 32'(valid),         32'd1);
      check("t3_hold_req", 32'(bus.mem_req_o), 32'd0);
    end
    stall = 1'b0;
    step();
    check("t3_rel_pc",   pc,                 32'hC);
    check("t3_rel_inst", inst,               32'h1000_000C);
    check("t3_rel_req",  32'(bus.mem_req_o), 32'd1);
    check("t3_rel_addr", bus.mem_addr_o,     32'h10);
    step();
    check("t3_next_pc",   pc,             32'h10);
    check("t3_next_addr", bus.mem_addr_o, 32'h14);

    // 2: latency-3 memory
    rst = 1'b1;
    lat = 3;
    step();
    rst = 1'b0;
    step();
    check("t2_addr0", bus.mem_addr_o, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t2_wait_val",  32'(valid),     32'd0);
      check("t2_wait_fst",  32'(fstall),    32'd1);
      check("t2_wait_addr", bus.mem_addr_o, 32'(4 * k));
      step();
      check("t2_wait2_val",  32'(valid),     32'd0);
      check("t2_wait2_addr", bus.mem_addr_o, 32'(4 * k));
      step();
      check("t2_pulse_val",  32'(valid),     32'd1);
      check("t2_pulse_pc",   pc,             32'(4 * k));
      check("t2_pulse_addr", bus.mem_addr_o, 32'(4 * k + 4));
    end

    // 4: latency 2, redirect while 0x10 is outstanding
    rst = 1'b1;
    lat = 2;
    step();
    rst = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      check("t4_wait_val", 32'(valid), 32'd0);
      step();
      check("t4_pc", pc, 32'(4 * k));
    end
    check("t4_pre_addr", bus.mem_addr_o, 32'h10);
    branch = 1'b1;
    target = 32'h103;
    step();
    branch = 1'b0;
    check("t4_br_val",  32'(valid),         32'd0);
    check("t4_br_req",  32'(bus.mem_req_o), 32'd1);
    check("t4_br_addr", bus.mem_addr_o,     32'h10);
    step();
    check("t4_drop_val",  32'(valid),     32'd0);
    check("t4_drop_addr", bus.mem_addr_o, 32'h100);
    step();
    check("t4_tgt_wait", 32'(valid), 32'd0);
    step();
    check("t4_tgt_val",  32'(valid),     32'd1);
    check("t4_tgt_pc",   pc,             32'h100);
    check("t4_tgt_inst", inst,           32'h1000_0100);
    check("t4_tgt_addr", bus.mem_addr_o, 32'h104);

    // 5: redirect at the same edge as the ack for 0x20
    rst = 1'b1;
    lat = 0;
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 8; i++) step();
    check("t5_pre_addr", bus.mem_addr_o, 32'h20);
    check("t5_pre_pc",   pc,             32'h1C);
    branch = 1'b1;
    target = 32'h200;
    step();
    branch = 1'b0;
    check("t5_br_addr", bus.mem_addr_o,     32'h200);
    check("t5_br_req",  32'(bus.mem_req_o), 32'd1);
    check("t5_br_val",  32'(valid),         32'd0);
    step();
    check("t5_tgt_pc",  pc,         32'h200);
    check("t5_tgt_val", 32'(valid), 32'd1);
    // branch while stalled is ignored
    stall  = 1'b1;
    branch = 1'b1;
    target = 32'h300;
    step();
    check("t5_st_pc",  pc,                 32'h200);
    check("t5_st_val", 32'(valid),         32'd1);
    check("t5_st_req", 32'(bus.mem_req_o), 32'd0);
    step();
    check("t5_st2_pc",   pc,             32'h200);
    check("t5_st2_addr", bus.mem_addr_o, 32'h204);
    stall  = 1'b0;
    branch = 1'b0;
    step();
    check("t5_rel_pc",   pc,             32'h204);
    check("t5_rel_addr", bus.mem_addr_o, 32'h208);
    step();
    check("t5_rel2_pc", pc, 32'h208);

    // 6: reset during a latency-3 request, ack arrives while in reset
    rst = 1'b1;
    lat = 3;
    step();
    rst = 1'b0;
    step();
    check("t6_req", 32'(bus.mem_req_o), 32'd1);
    rst       = 1'b1;
    ack_force = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("t6_rst_req",  32'(bus.mem_req_o), 32'd0);
      check("t6_rst_addr", bus.mem_addr_o,     32'h0);
      check("t6_rst_pc",   pc,                 32'h0);
      check("t6_rst_inst", inst,               32'h0);
      check("t6_rst_val",  32'(valid),         32'd0);
    end
    rst       = 1'b0;
    ack_force = 1'b0;
    step();
    check("t6_rel_req",  32'(bus.mem_req_o), 32'd1);
    check("t6_rel_addr", bus.mem_addr_o,     32'h0);
    check("t6_rel_val",  32'(valid),         32'd0);

    // 7: redirect near the top of memory; PC wraps to 0
    lat    = 0;
    branch = 1'b1;
    target = 32'hFFFF_FFFF;
    step();
    branch = 1'b0;
    check("t7_addr", bus.mem_addr_o, 32'hFFFF_FFFC);
    step();
    check("t7_pc",        pc,             32'hFFFF_FFFC);
    check("t7_wrap_addr", bus.mem_addr_o, 32'h0);
    step();
    check("t7_wrap_pc",  pc,         32'h0);
    check("t7_wrap_val", 32'(valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction fetch stage; the producer side of the decode stage's `pc_i`/`inst_i` inputs.
- Holds the fetch PC and issues one-outstanding req/ack reads to instruction memory.
- Buffers returned instructions in an output register plus a one-entry skid buffer, and presents them to decode.
- Redirects on `branch_flag`/`branch_target_address` from decode, squashing wrong-path instructions and in-flight responses.

Parameters:
- RESET_PC, 32'h00000000, fetch address after reset.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high (`RstEnable` = 1'b1).
- stall_i  input  1  decode stage not accepting; hold the output instruction.
- branch_flag_i  input  1  redirect request from decode.
- branch_target_address_i  input  32  redirect target.
- mem_req_o  output  1  instruction memory read request; registered.
- mem_addr_o  output  32  read address; registered, stable while `mem_req_o` is high.
- mem_ack_i  input  1  read complete; `mem_rdata_i` is valid in the same cycle.
- mem_rdata_i  input  32  instruction word.
- pc_o  output  32  PC of the presented instruction; registered.
- inst_o  output  32  presented instruction; registered.
- inst_valid_o  output  1  `pc_o`/`inst_o` are valid; registered.
- fetch_stall_o  output  1  combinational, equals `!inst_valid_o`; feeds ctrl.

Behaviour:
- Reset, sampled at an edge:
  - `mem_req_o`=0, `mem_addr_o`=0, `pc_o`=0, `inst_o`=0, `inst_valid_o`=0.
  - Skid buffer invalid, `drop_pending`=0, fetch PC=RESET_PC.
  - `mem_ack_i` at that edge is ignored.
- First edge with rst=0: `mem_req_o`←1, `mem_addr_o`←RESET_PC.
- Memory handshake:
  - A transfer completes at an edge where `mem_req_o`=1 and `mem_ack_i`=1.
  - `mem_ack_i` while `mem_req_o`=0 is ignored.
  - At most one request is outstanding.
  - `mem_addr_o` changes only at a completing edge or when a request is (re)issued.
- Output consumption: the output register is consumed at any edge with `inst_valid_o`=1 and `stall_i`=0.
- Fill priority on completion (not dropped): output register if empty or being consumed; else skid buffer.
  - A consumed output is refilled from the skid buffer first, then from memory data.
  - Order is strictly preserved: no loss, no duplication.
- Request issue on a completing edge:
  - If the skid buffer will be free after this edge: keep `mem_req_o`=1 and set `mem_addr_o` to the next PC. This gives 1 instr/cycle with zero-wait memory.
  - Otherwise `mem_req_o`←0. Re-raise it at the edge where the skid buffer drains.
- States (encoded by req, `drop_pending`, buffer valids):
  - FETCH: request outstanding.
  - DROP: request outstanding, response discarded.
  - FULL: both buffers valid, no request.
- Redirect: `branch_flag_i`=1 at an edge with `stall_i`=0.
  - The output register and skid buffer are invalidated; the redirect overrides consumption/fill.
  - Fetch PC ← {target[31:2],2'b00}.
  - Outstanding request without ack this edge: `drop_pending`←1 (DROP). On its ack, discard data, clear `drop_pending`, issue a request at the target next cycle.
  - Ack at the same edge as the redirect: data discarded; `mem_addr_o`←target with `mem_req_o`=1 at that edge.
  - No outstanding request (FULL): issue the target request immediately.
  - `branch_flag_i` with `stall_i`=1 is ignored; decode re-presents it.
- A redirect while in DROP replaces the target; `drop_pending` stays 1.
- PC arithmetic: 32-bit modulo; 0xFFFFFFFC+4 wraps to 0.
- Reset mid-operation overrides everything: in-flight request abandoned, `drop_pending` cleared, fetch restarts at RESET_PC.
- Latency: ack at edge E gives `inst_valid_o`=1 from E (output empty), visible in the cycle after E.

Test Plan:
1. Reset 2 cycles, zero-wait memory (ack whenever req), `stall_i`=0 -> `mem_addr_o` 0,4,8,C on consecutive cycles; `pc_o` 0,4,8 one cycle later; `inst_valid_o` continuously 1.
2. Memory ack 3 cycles after each request -> `mem_addr_o` held for 3 cycles; `inst_valid_o` is a 1-cycle pulse per instruction with `fetch_stall_o`=1 between; `pc_o` 0,4,8.
3. Zero-wait memory, `stall_i`=1 for 4 cycles while `pc_o`=0x8 -> `pc_o` held at 0x8; skid buffer captures 0xC; `mem_req_o` drops; after release `pc_o` = 0x8,0xC,0x10 with no gaps or duplicates.
4. Memory latency 2, request at 0x10 outstanding, `branch_flag_i`=1 with target 0x103 -> 0x10 data discarded; next `mem_addr_o`=0x100; next valid `pc_o`=0x100; no valid instruction from 0x10/0x14.
5. Redirect to 0x200 at the same edge as an ack for 0x20 -> `mem_addr_o`=0x200 at that edge; 0x20 never presented. Second case: `branch_flag_i`=1 with `stall_i`=1 -> no redirect.
6. rst asserted one cycle into a latency-3 request, ack arrives during reset -> all outputs zero; ack ignored; first `mem_addr_o` after release = RESET_PC.
